// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86-64 instruction codes, status codes and memory-stage types
package y86_pkg;
    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [2:0] SAOK = 3'd1;
    localparam logic [2:0] SHLT = 3'd2;
    localparam logic [2:0] SADR = 3'd3;
    localparam logic [2:0] SINS = 3'd4;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_HALTED} state_t;

    function automatic logic is_read(input logic [3:0] ic);
        return ic == IMRMOVQ || ic == IRET || ic == IPOPQ;
    endfunction

    function automatic logic is_write(input logic [3:0] ic);
        return ic == IRMMOVQ || ic == ICALL || ic == IPUSHQ;
    endfunction
endpackage

// File: rtl/memory_stage_data_mem.sv
// data_mem: byte array with one 8-byte synchronous write port and two 8-byte combinational read ports
module data_mem #(
    parameter int MEM_BYTES = 1024,
    parameter int AW = $clog2(MEM_BYTES)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [63:0]   wdata,
    input  logic [AW-1:0] raddr_a,
    output logic [63:0]   rdata_a,
    input  logic [AW-1:0] raddr_b,
    output logic [63:0]   rdata_b
);
    logic [7:0] mem [MEM_BYTES];

    always_ff @(posedge clk) begin
        if (we)
            for (int i = 0; i < 8; i++)
                mem[waddr + AW'(i)] <= wdata[8*i +: 8];
    end

    always_comb begin
        rdata_a = '0;
        rdata_b = '0;
        for (int i = 0; i < 8; i++) begin
            rdata_a[8*i +: 8] = mem[raddr_a + AW'(i)];
            rdata_b[8*i +: 8] = mem[raddr_b + AW'(i)];
        end
    end
endmodule

// File: rtl/memory_stage.sv
// memory_stage: Y86-64 memory stage with valid/ready handshake, one op per cycle and sticky halt on error status
module memory_stage
    import y86_pkg::*;
#(
    parameter int MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  icode,
    input  logic        cnd,
    input  logic [63:0] valE,
    input  logic [63:0] valA,
    input  logic [63:0] valP,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] valM,
    output logic [63:0] valE_o,
    output logic        cnd_o,
    output logic [3:0]  icode_o,
    output logic [2:0]  stat,
    input  logic [63:0] dbg_addr,
    output logic [63:0] dbg_data
);
    localparam int AW = $clog2(MEM_BYTES);
    localparam logic [63:0] LAST_ADDR = 64'(MEM_BYTES - 8);

    state_t      state_q, state_d;
    logic [63:0] valm_q, valm_d, vale_q, vale_d;
    logic        cnd_q, cnd_d;
    logic [3:0]  icode_q, icode_d;
    logic [2:0]  stat_q, stat_d;
    logic        rd, wr, adr_err, accept, we;
    logic [63:0] addr, wdata, rdata, dbg_raw;
    logic [2:0]  new_stat;

    always_comb begin
        rd       = is_read(icode);
        wr       = is_write(icode);
        addr     = (icode == IRET || icode == IPOPQ) ? valA : valE;
        adr_err  = (rd || wr) && addr > LAST_ADDR;
        new_stat = adr_err ? SADR : icode == IHALT ? SHLT : icode > IPOPQ ? SINS : SAOK;
        wdata    = icode == ICALL ? valP : valA;
        accept   = in_valid && in_ready;
        we       = accept && wr && !adr_err;
    end

    data_mem #(.MEM_BYTES(MEM_BYTES), .AW(AW)) u_mem (
        .clk     (clk),
        .we      (we),
        .waddr   (addr[AW-1:0]),
        .wdata   (wdata),
        .raddr_a (addr[AW-1:0]),
        .rdata_a (rdata),
        .raddr_b (dbg_addr[AW-1:0]),
        .rdata_b (dbg_raw)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            valm_q  <= '0;
            vale_q  <= '0;
            cnd_q   <= 1'b0;
            icode_q <= '0;
            stat_q  <= SAOK;
        end else begin
            state_q <= state_d;
            valm_q  <= valm_d;
            vale_q  <= vale_d;
            cnd_q   <= cnd_d;
            icode_q <= icode_d;
            stat_q  <= stat_d;
        end
    end

    // An error result only halts the stage once downstream has taken it
    always_comb begin
        state_d = state_q == S_IDLE ? (accept ? S_BUSY : S_IDLE)
                : state_q == S_BUSY ? (!out_ready ? S_BUSY
                                      : stat_q != SAOK ? S_HALTED
                                      : accept ? S_BUSY : S_IDLE)
                : S_HALTED;
    end

    always_comb begin
        valm_d  = accept ? ((rd && !adr_err) ? rdata : '0) : valm_q;
        vale_d  = accept ? valE : vale_q;
        cnd_d   = accept ? cnd : cnd_q;
        icode_d = accept ? icode : icode_q;
        stat_d  = accept ? new_stat : stat_q;
    end

    always_comb begin
        in_ready  = state_q == S_IDLE || (state_q == S_BUSY && out_ready && stat_q == SAOK);
        out_valid = state_q == S_BUSY;
        valM      = valm_q;
        valE_o    = vale_q;
        cnd_o     = cnd_q;
        icode_o   = icode_q;
        stat      = stat_q;
        dbg_data  = dbg_addr > LAST_ADDR ? '0 : dbg_raw;
    end
endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: randomized scoreboard bench for memory_stage against a byte-array reference model
module tb_memory_stage;
    localparam int MB = 1024;

    logic        clk = 0, rst_n = 1, in_valid = 0, in_ready, cnd = 0;
    logic        out_valid, out_ready = 1, cnd_o;
    logic [3:0]  icode = 0, icode_o;
    logic [63:0] valE = 0, valA = 0, valP = 0, valM, valE_o, dbg_addr = 0, dbg_data;
    logic [2:0]  stat;

    typedef struct packed {
        logic [63:0] valm;
        logic [63:0] vale;
        logic        cnd;
        logic [3:0]  icode;
        logic [2:0]  stat;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] mem_m [MB];
    int         checks = 0, errors = 0;
    bit         rdy_mode = 0, rdy_force = 1;

    always #5 clk = ~clk;

    memory_stage #(.MEM_BYTES(MB)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .icode(icode), .cnd(cnd), .valE(valE), .valA(valA), .valP(valP),
        .out_valid(out_valid), .out_ready(out_ready), .valM(valM),
        .valE_o(valE_o), .cnd_o(cnd_o), .icode_o(icode_o), .stat(stat),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [3:0] ic, input logic c, input logic [63:0] e, a, p);
        exp_t r;
        logic rd, wr, bad;
        logic [63:0] adr, wd;
        rd  = ic == 4'h5 || ic == 4'h9 || ic == 4'hB;
        wr  = ic == 4'h4 || ic == 4'h8 || ic == 4'hA;
        adr = (ic == 4'h9 || ic == 4'hB) ? a : e;
        bad = (rd || wr) && adr > 64'(MB - 8);
        wd  = ic == 4'h8 ? p : a;
        r.stat  = bad ? 3'd3 : ic == 4'h0 ? 3'd2 : ic > 4'hB ? 3'd4 : 3'd1;
        r.valm  = '0;
        r.vale  = e;
        r.cnd   = c;
        r.icode = ic;
        for (int i = 0; i < 8; i++) begin
            int k;
            k = int'(adr[9:0]) + i;
            if (!bad && wr) mem_m[k] = wd[8*i +: 8];
            if (!bad && rd) r.valm[8*i +: 8] = mem_m[k];
        end
        return r;
    endfunction

    task automatic dbg_chk(input logic [63:0] a);
        logic [63:0] e;
        e = '0;
        for (int i = 0; i < 8; i++) e[8*i +: 8] = mem_m[int'(a[9:0]) + i];
        dbg_addr = a;
        #1;
        chk("dbg_data", dbg_data, e);
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge
    task automatic send(input logic [3:0] ic, input logic c, input logic [63:0] e, a, p,
                        output exp_t r, output int waited);
        icode = ic; cnd = c; valE = e; valA = a; valP = p; in_valid = 1;
        waited = 0;
        r = '0;
        r.stat = 3'd1;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        chk("accept_ready", 64'(in_ready), 64'd1);
        if (in_ready) begin
            r = model(ic, c, e, a, p);
            exp_q.push_back(r);
        end
        @(posedge clk);
        #1;
        in_valid = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_stat", 64'(stat), 64'd1);
        chk("rst_valM", valM, 64'd0);
        chk("rst_valE_o", valE_o, 64'd0);
        chk("rst_icode_o", 64'(icode_o), 64'd0);
        chk("rst_cnd_o", 64'(cnd_o), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic halt_seq(input logic [2:0] st);
        drain();
        chk("halt_in_ready", 64'(in_ready), 64'd0);
        chk("halt_out_valid", 64'(out_valid), 64'd0);
        chk("halt_stat", 64'(stat), 64'(st));
        icode = 4'h4; valE = 64'h100; valA = '1; in_valid = 1;
        repeat (4) begin
            @(negedge clk);
            chk("halt_ignore_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        in_valid = 0;
        dbg_chk(64'h100);
        do_reset();
    endtask

    always begin
        @(posedge clk);
        #2;
        out_ready = rdy_mode ? rdy_force : ($urandom % 4 != 0);
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: out_valid with empty scoreboard, icode_o 0x%0h at %0t", icode_o, $time);
                end else begin
                    e = exp_q[0];
                    chk("valM", valM, e.valm);
                    chk("valE_o", valE_o, e.vale);
                    chk("cnd_o", 64'(cnd_o), 64'(e.cnd));
                    chk("icode_o", 64'(icode_o), 64'(e.icode));
                    chk("stat", 64'(stat), 64'(e.stat));
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d errors so far", errors);
        $fatal(1, "watchdog");
    end

    initial begin : main
        exp_t r;
        int   w;
        #1 rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("init_out_valid", 64'(out_valid), 64'd0);
        chk("init_stat", 64'(stat), 64'd1);
        chk("init_valM", valM, 64'd0);
        chk("init_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;

        for (int i = 0; i < MB / 8; i++)
            send(4'h4, 1'b0, 64'(i * 8), {$urandom, $urandom}, 64'd0, r, w);

        send(4'h4, 1'b1, 64'h100, 64'h1122334455667788, 64'd0, r, w);
        send(4'h5, 1'b0, 64'h100, 64'd0, 64'd0, r, w);
        send(4'h8, 1'b0, 64'h1F8, 64'd0, 64'h42, r, w);
        send(4'h9, 1'b1, 64'd0, 64'h1F8, 64'd0, r, w);
        drain();
        dbg_addr = 64'h1F8;
        #1;
        chk("dbg_1f8_byte", 64'(dbg_data[7:0]), 64'h42);
        dbg_chk(64'h100);

        rdy_mode = 1; rdy_force = 0;
        send(4'h5, 1'b1, 64'h1F8, 64'd0, 64'd0, r, w);
        repeat (3) begin
            @(negedge clk);
            chk("stall_out_valid", 64'(out_valid), 64'd1);
            chk("stall_in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        rdy_force = 1;
        send(4'h4, 1'b0, 64'h208, 64'hDEADBEEFCAFEF00D, 64'd0, r, w);
        chk("release_same_cycle", 64'(w), 64'd0);
        drain();

        rdy_force = 0;
        send(4'h4, 1'b0, 64'h200, 64'h0123456789ABCDEF, 64'd0, r, w);
        @(posedge clk);
        #1;
        do_reset();
        dbg_chk(64'h200);
        rdy_mode = 0;

        send(4'h5, 1'b0, 64'h3F9, 64'd0, 64'd0, r, w);
        halt_seq(r.stat);
        send(4'hC, 1'b0, 64'd0, 64'd0, 64'd0, r, w);
        halt_seq(r.stat);
        send(4'h0, 1'b0, 64'd0, 64'd0, 64'd0, r, w);
        halt_seq(r.stat);

        for (int n = 0; n < 400; n++) begin
            int          sel;
            logic [3:0]  ic;
            logic [63:0] adr, data;
            logic        rr;
            sel  = int'($urandom % 40);
            ic   = sel == 0 ? (($urandom % 2) != 0 ? 4'h0 : 4'(12 + $urandom % 4)) : 4'(1 + $urandom % 11);
            adr  = ($urandom % 2) != 0 ? 64'(256 + 8 * ($urandom % 8)) : 64'($urandom_range(0, MB - 8));
            if (sel == 1) adr = ($urandom % 2) != 0 ? 64'(MB - 7 + $urandom % 7) : {$urandom | 32'h1, $urandom};
            data = {$urandom, $urandom};
            rr   = ic == 4'h9 || ic == 4'hB;
            send(ic, 1'($urandom % 2), rr ? data : adr, rr ? adr : data, {$urandom, $urandom}, r, w);
            if (r.stat != 3'd1) halt_seq(r.stat);
            else if ($urandom % 4 == 0) dbg_chk(64'($urandom_range(0, MB - 8)));
            else if ($urandom % 5 == 0) begin
                @(posedge clk);
                #1;
            end
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 1024, data-memory size in bytes.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst_n  input  1  reset; one clock, reset asynchronous and active-low.
REQ-004 SHALL have port in_valid  input  1  upstream execute result valid.
REQ-005 SHALL have port in_ready  output  1  stage can accept a transaction.
REQ-006 SHALL have port icode  input  4  instruction code.
REQ-007 SHALL have port cnd  input  1  condition from execute; passed through.
REQ-008 SHALL have port valE  input  64  ALU result / address.
REQ-009 SHALL have port valA  input  64  register operand / stack address.
REQ-010 SHALL have port valP  input  64  next PC.
REQ-011 SHALL have port out_valid  output  1  result valid.
REQ-012 SHALL have port out_ready  input  1  downstream accepts result.
REQ-013 SHALL have port valM  output  64  memory read data.
REQ-014 SHALL have port valE_o, cnd_o, icode_o  output  64/1/4  registered pass-through.
REQ-015 SHALL have port stat  output  3  status: AOK=1, HLT=2, ADR=3, INS=4.
REQ-016 SHALL have port dbg_addr  input  64 and dbg_data  output  64  combinational 8-byte little-endian read for test.

Function
REQ-017 SHALL accept a transaction on a rising edge where in_valid && in_ready.
REQ-018 SHALL select address: valE for icode 4,5,8,A; valA for icode 9,B; no access otherwise.
REQ-019 SHALL write valA for icode 4 and A, valP for icode 8; read for icode 5,9,B; 8 bytes, little-endian.
REQ-020 SHALL perform the write on the accepting edge; read data SHALL appear on valM with out_valid one cycle later.
REQ-021 SHALL drive valM to 0 for non-read icodes.
REQ-022 SHALL flag ADR when address > MEM_BYTES-8 (unsigned, full 64-bit compare); no write occurs, valM = 0.
REQ-023 SHALL flag INS for icode > 0xB, HLT for icode 0, ADR taking priority over HLT/INS only for access icodes; AOK otherwise.
REQ-024 SHALL implement FSM IDLE, BUSY, HALTED: IDLE->BUSY on accept; BUSY->IDLE when out_ready and stat==AOK; BUSY->HALTED when out_ready and stat!=AOK; HALTED absorbing until reset.
REQ-025 SHALL drive in_ready = 1 only in IDLE, or in BUSY with out_ready high and stat AOK (back-to-back, one op per cycle).
REQ-026 SHALL hold all outputs stable while out_valid && !out_ready.
REQ-027 SHALL keep out_valid low in IDLE and HALTED; stat SHALL retain its last non-AOK value in HALTED.
REQ-028 SHALL ignore in_valid in HALTED with no memory write.
REQ-029 SHALL make a back-to-back read of an address written in the preceding accepted cycle return the new data.

Reset
REQ-030 SHALL on rst_n low immediately force state IDLE, out_valid 0, valM/valE_o/icode_o/cnd_o 0, stat AOK.
REQ-031 SHALL abort an in-flight BUSY result on reset; memory contents SHALL NOT be reset.

Structure
REQ-032 SHALL take icode constants (IHALT..IPOPQ) and stat codes from shared package y86_pkg.
REQ-033 SHALL instantiate one sub-module data_mem (byte array, one 8-byte synchronous write port, two 8-byte combinational read ports).

Verification
REQ-034 rmmovq icode 4, valE=0x100, valA=0x1122334455667788, then mrmovq icode 5 valE=0x100 -> valM=0x1122334455667788, stat 1.
REQ-035 call icode 8 valE=0x1F8 valP=0x42, then ret icode 9 valA=0x1F8 -> valM=0x42; byte 0x1F8 reads 0x42 via dbg.
REQ-036 mrmovq valE=0x3F9 (MEM_BYTES 1024) -> stat 3, valM 0, state HALTED, in_ready 0; further writes ignored.
REQ-037 icode 0xC -> stat 4; icode 0 -> stat 2; both halt the stage.
REQ-038 hold out_ready low 3 cycles with BUSY result -> outputs constant, in_ready 0; release -> next accept same cycle.
REQ-039 assert rst_n low mid-BUSY -> out_valid 0, stat 1 without clock edge; prior memory write retained.
